// File: rtl/esp8266_frame_scheduler.sv
// Round-robin scheduler that serialises one 15-byte m("T","12.5")\r\n frame per
// granted channel onto a shared valid/ready UART byte stream, with an idle gap after each frame.
module esp8266_frame_scheduler #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned GAP_CYCLES = 2500
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [N_CH-1:0]     Req,
    input  logic [32*N_CH-1:0]  Data_in,
    output logic [N_CH-1:0]     Ack,
    output logic [7:0]          Tx_data,
    output logic                Tx_valid,
    input  logic                Tx_ready,
    output logic                Busy,
    output logic [CH_W-1:0]     Cur_ch,
    output logic [15:0]         Frame_cnt
);

    typedef enum logic [1:0] {StIdle, StArb, StSend, StGap} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [31:0]       word_q, word_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       gap_q, gap_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic [N_CH-1:0]   ack_q, ack_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              found;
    logic [CH_W-1:0]   grant;
    logic [31:0]       grant_word;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int unsigned b);
        return CH_W'((32'(a) + b) % N_CH);
    endfunction

    // Out-of-range digit fields render as '?' so a bad sensor value is visible on the wire.
    function automatic logic [7:0] digit(input logic [7:0] x);
        return (x <= 8'd9) ? x + 8'h30 : 8'h3F;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            4'd0:  b = 8'h6D;
            4'd1:  b = 8'h28;
            4'd2:  b = 8'h22;
            4'd3:  b = w[31:24];
            4'd4:  b = 8'h22;
            4'd5:  b = 8'h2C;
            4'd6:  b = 8'h22;
            4'd7:  b = digit(w[23:16]);
            4'd8:  b = digit(w[15:8]);
            4'd9:  b = 8'h2E;
            4'd10: b = digit(w[7:0]);
            4'd11: b = 8'h22;
            4'd12: b = 8'h29;
            4'd13: b = 8'h0D;
            4'd14: b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // First requester at or after the rotation pointer.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && Req[wrap_add(rr_q, i)]) begin
                found = 1'b1;
                grant = wrap_add(rr_q, i);
            end
        end
        grant_word = Data_in[32*grant +: 32];
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cur_ch_d    = cur_ch_q;
        word_d      = word_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        ack_d       = '0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                if (|Req) state_d = StArb;
            end
            StArb: begin
                if (found) begin
                    word_d     = grant_word;
                    cur_ch_d   = grant;
                    rr_d       = wrap_add(grant, 1);
                    idx_d      = 4'd0;
                    tx_data_d  = frame_byte(grant_word, 4'd0);
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (tx_valid_q && Tx_ready) begin
                    if (idx_q == 4'd14) begin
                        tx_valid_d      = 1'b0;
                        ack_d[cur_ch_q] = 1'b1;
                        frame_cnt_d     = frame_cnt_q + 16'd1;
                        gap_d           = '0;
                        state_d         = (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = frame_byte(word_q, idx_q + 4'd1);
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_CYCLES - 1) state_d = StIdle;
                else gap_d = gap_q + 32'd1;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            cur_ch_q    <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cur_ch_q    <= cur_ch_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Ack       = ack_q;
    assign Tx_data   = tx_data_q;
    assign Tx_valid  = tx_valid_q;
    assign Busy      = busy_q;
    assign Cur_ch    = cur_ch_q;
    assign Frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_esp8266_frame_scheduler.sv
// Directed bench for esp8266_frame_scheduler: reset, single frames, rotation,
// back-pressure, digit substitution, counter wrap and mid-frame Req drop.
module tb_esp8266_frame_scheduler;

    localparam int unsigned NCh = 4;
    localparam int unsigned ChW = 2;
    localparam int unsigned Gap = 4;

    localparam logic [119:0] FrmT125 = {8'h6D, 8'h28, 8'h22, 8'h54, 8'h22, 8'h2C, 8'h22,
                                        8'h31, 8'h32, 8'h2E, 8'h35, 8'h22, 8'h29, 8'h0D, 8'h0A};
    localparam logic [119:0] FrmH9   = {8'h6D, 8'h28, 8'h22, 8'h48, 8'h22, 8'h2C, 8'h22,
                                        8'h39, 8'h3F, 8'h2E, 8'h3F, 8'h22, 8'h29, 8'h0D, 8'h0A};

    logic               Clk = 1'b0;
    logic               Rst;
    logic [NCh-1:0]     Req;
    logic [32*NCh-1:0]  Data_in;
    logic [NCh-1:0]     Ack;
    logic [7:0]         Tx_data;
    logic               Tx_valid;
    logic               Tx_ready;
    logic               Busy;
    logic [ChW-1:0]     Cur_ch;
    logic [15:0]        Frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pre_low, busy_low, first_cyc, last_cyc;
    logic [119:0] frm_rr [4];

    esp8266_frame_scheduler #(
        .N_CH       (NCh),
        .CH_W       (ChW),
        .GAP_CYCLES (Gap)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .Data_in   (Data_in),
        .Ack       (Ack),
        .Tx_data   (Tx_data),
        .Tx_valid  (Tx_valid),
        .Tx_ready  (Tx_ready),
        .Busy      (Busy),
        .Cur_ch    (Cur_ch),
        .Frame_cnt (Frame_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int ch, input logic [31:0] w);
        Data_in[32*ch +: 32] = w;
    endtask

    // mode 0: Tx_ready always high; mode 1: ready 1,0,0 repeating over valid cycles.
    // drop_at: Req cleared once that many bytes have been accepted (-1 = never).
    task automatic collect_frame(input string tag, input int mode, input int drop_at,
                                 input logic [3:0] exp_ack, input logic [1:0] exp_ch,
                                 input logic [119:0] exp_frm, input logic [15:0] exp_cnt);
        logic [119:0] frm;
        logic [7:0]   prev;
        logic         stall_prev, rdy;
        int           k, cyc, ph;
        frm = '0; prev = '0; stall_prev = 1'b0;
        k = 0; cyc = 0; ph = 0;
        pre_low = 0; busy_low = 0; first_cyc = -1; last_cyc = -1;
        while (k < 15 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) check_eq({tag, "_ack_one_cycle"}, Ack, 0);
            if (stall_prev) check_eq({tag, "_stall_hold"}, Tx_data, prev);
            if (!Tx_valid && k == 0) pre_low++;
            if (!Busy && k == 0) busy_low++;
            if (Tx_valid) begin
                rdy = (mode == 0) || (ph % 3 == 0);
                ph++;
            end else begin
                rdy = 1'b1;
            end
            Tx_ready = rdy;
            if (Tx_valid && rdy) begin
                frm = {frm[111:0], Tx_data};
                if (k == 0) first_cyc = cyc;
                last_cyc = cyc;
                k++;
                if (k == drop_at) Req = '0;
            end
            stall_prev = Tx_valid && !rdy;
            prev = Tx_data;
        end
        check_eq({tag, "_byte_count"}, k, 15);
        check_eq({tag, "_frame"}, frm, exp_frm);
        @(negedge Clk);
        check_eq({tag, "_ack"}, Ack, exp_ack);
        check_eq({tag, "_valid_low_after"}, Tx_valid, 1'b0);
        check_eq({tag, "_cur_ch"}, Cur_ch, exp_ch);
        check_eq({tag, "_frame_cnt"}, Frame_cnt, exp_cnt);
        check_eq({tag, "_busy_in_gap"}, Busy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        frm_rr[0] = {8'h6D, 8'h28, 8'h22, 8'h41, 8'h22, 8'h2C, 8'h22,
                     8'h31, 8'h32, 8'h2E, 8'h33, 8'h22, 8'h29, 8'h0D, 8'h0A};
        frm_rr[1] = {8'h6D, 8'h28, 8'h22, 8'h42, 8'h22, 8'h2C, 8'h22,
                     8'h34, 8'h35, 8'h2E, 8'h36, 8'h22, 8'h29, 8'h0D, 8'h0A};
        frm_rr[2] = {8'h6D, 8'h28, 8'h22, 8'h43, 8'h22, 8'h2C, 8'h22,
                     8'h37, 8'h38, 8'h2E, 8'h39, 8'h22, 8'h29, 8'h0D, 8'h0A};
        frm_rr[3] = {8'h6D, 8'h28, 8'h22, 8'h44, 8'h22, 8'h2C, 8'h22,
                     8'h30, 8'h30, 8'h2E, 8'h31, 8'h22, 8'h29, 8'h0D, 8'h0A};
        Rst = 1'b0; Req = '0; Data_in = '0; Tx_ready = 1'b0;
        #2 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        check_eq("reset_outputs", {Tx_data, Tx_valid, Ack, Busy, Cur_ch, Frame_cnt}, 0);
        Rst = 1'b0;

        // Single frame at full rate, latency and back-to-back bytes.
        set_word(0, {8'h54, 8'd1, 8'd2, 8'd5});
        Tx_ready = 1'b1;
        Req = 4'b0001;
        collect_frame("s2", 0, 15, 4'b0001, 2'd0, FrmT125, 16'd1);
        check_eq("s2_first_valid_latency", first_cyc, 2);
        check_eq("s2_consecutive", last_cyc - first_cyc, 14);
        repeat (Gap + 2) @(negedge Clk);

        // Async reset while byte 6 is presented; frame restarts from byte 0.
        Req = 4'b0001;
        k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            Tx_ready = 1'b1;
            if (Tx_valid) begin
                if (k == 6) break;
                k++;
            end
        end
        check_eq("s1_at_byte6", {k[3:0], Tx_data}, {4'd6, 8'h22});
        Rst = 1'b1;
        #1;
        check_eq("s1_async_reset", {Tx_valid, Ack, Busy, Frame_cnt}, 0);
        @(negedge Clk);
        Rst = 1'b0;
        collect_frame("s1_restart", 0, 15, 4'b0001, 2'd0, FrmT125, 16'd1);
        check_eq("s1_restart_latency", first_cyc, 2);
        repeat (Gap + 2) @(negedge Clk);

        // All channels requesting: rotation 0,1,2,3,0 with a fixed inter-frame gap.
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        set_word(0, {8'h41, 8'd1, 8'd2, 8'd3});
        set_word(1, {8'h42, 8'd4, 8'd5, 8'd6});
        set_word(2, {8'h43, 8'd7, 8'd8, 8'd9});
        set_word(3, {8'h44, 8'd0, 8'd0, 8'd1});
        Req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            collect_frame($sformatf("s3_f%0d", f), 0, (f == 4) ? 15 : -1,
                          4'(1 << (f % 4)), 2'(f % 4), frm_rr[f % 4], 16'(f + 1));
            if (f > 0) begin
                // GAP cycles plus one IDLE and one ARB cycle with Tx_valid low.
                check_eq($sformatf("s3_f%0d_valid_gap", f), pre_low + 1, Gap + 2);
                check_eq($sformatf("s3_f%0d_idle_cycles", f), busy_low, 1);
            end
        end
        repeat (Gap + 2) @(negedge Clk);

        // Back-pressure: ready 1,0,0 repeating.
        set_word(0, {8'h54, 8'd1, 8'd2, 8'd5});
        Req = 4'b0001;
        collect_frame("s4", 1, 15, 4'b0001, 2'd0, FrmT125, 16'd6);
        check_eq("s4_stall_spacing", last_cyc - first_cyc, 42);
        Tx_ready = 1'b1;
        repeat (Gap + 2) @(negedge Clk);

        // Out-of-range digits become '?'.
        set_word(0, {8'h48, 8'd9, 8'd10, 8'd255});
        Req = 4'b0001;
        collect_frame("s5", 0, 15, 4'b0001, 2'd0, FrmH9, 16'd7);
        repeat (Gap + 2) @(negedge Clk);

        // Counter wrap, with Req[2] dropped after byte 3 on the first frame.
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        Req = 4'b0100;
        collect_frame("s6_drop", 0, 3, 4'b0100, 2'd2, frm_rr[2], 16'hFFFF);
        repeat (Gap + 2) @(negedge Clk);
        Req = 4'b0100;
        collect_frame("s6_wrap", 0, 15, 4'b0100, 2'd2, frm_rr[2], 16'h0000);
        repeat (Gap + 2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
